// File: rtl/seq_alu.sv
// Sequential RV32/64-style ALU: single-cycle base/branch ops, iterative M-extension ops.
// Valid/ready handshake on both sides; one operation in flight at a time.
module seq_alu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            ALU_source,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic [XLEN-1:0] immediate,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch,
    output logic            busy
);

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpB    = 7'b1100011;
    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7M    = 7'b0000001;

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e              state_q, state_d;
    logic [SHW-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     a_raw_q, a_raw_d;
    logic [2:0]          f3_q, f3_d;
    logic                neg_q, neg_d, a_neg_q, a_neg_d, dz_q, dz_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                branch_q, branch_d;

    // Base-op decode
    logic [XLEN-1:0] op2, base_res;
    logic [SHW-1:0]  shamt;
    logic            base_br, is_m, lt_s, lt_u;

    always_comb begin
        op2      = ALU_source ? immediate : reg2;
        shamt    = op2[SHW-1:0];
        lt_s     = $signed(reg1) < $signed(op2);
        lt_u     = reg1 < op2;
        base_res = '0;
        base_br  = 1'b0;
        is_m     = 1'b0;
        case (opcode)
            OpR: begin
                if (funct7 == F7M) begin
                    is_m = 1'b1;
                end else if (funct7 == F7Base) begin
                    case (funct3)
                        3'b000:  base_res = reg1 + op2;
                        3'b001:  base_res = reg1 << shamt;
                        3'b010:  base_res = XLEN'(lt_s);
                        3'b011:  base_res = XLEN'(lt_u);
                        3'b100:  base_res = reg1 ^ op2;
                        3'b101:  base_res = reg1 >> shamt;
                        3'b110:  base_res = reg1 | op2;
                        default: base_res = reg1 & op2;
                    endcase
                end else if (funct7 == F7Alt) begin
                    if (funct3 == 3'b000) base_res = reg1 - op2;
                    if (funct3 == 3'b101) base_res = XLEN'($signed(reg1) >>> shamt);
                end
            end
            OpI: begin
                case (funct3)
                    3'b000:  base_res = reg1 + op2;
                    3'b001:  base_res = (funct7 == F7Base) ? reg1 << shamt : '0;
                    3'b010:  base_res = XLEN'(lt_s);
                    3'b011:  base_res = XLEN'(lt_u);
                    3'b100:  base_res = reg1 ^ op2;
                    3'b101: begin
                        if (funct7 == F7Base)     base_res = reg1 >> shamt;
                        else if (funct7 == F7Alt) base_res = XLEN'($signed(reg1) >>> shamt);
                    end
                    3'b110:  base_res = reg1 | op2;
                    default: base_res = reg1 & op2;
                endcase
            end
            OpB: begin
                case (funct3)
                    3'b000:  base_br = reg1 == reg2;
                    3'b001:  base_br = reg1 != reg2;
                    3'b100:  base_br = $signed(reg1) < $signed(reg2);
                    3'b101:  base_br = $signed(reg1) >= $signed(reg2);
                    3'b110:  base_br = reg1 < reg2;
                    3'b111:  base_br = reg1 >= reg2;
                    default: base_br = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // Operand magnitudes and sign bookkeeping for M ops
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        b_signed = a_signed && (funct3 != 3'b010);
        a_neg    = a_signed && reg1[XLEN-1];
        b_neg    = b_signed && reg2[XLEN-1];
        a_mag    = a_neg ? -reg1 : reg1;
        b_mag    = b_neg ? -reg2 : reg2;
    end

    // One iteration: shift-add multiply (f3[2]=0) or restoring divide (f3[2]=1)
    logic [XLEN:0]     add_sum, div_shift;
    logic [XLEN-1:0]   div_rem, quo, rem;
    logic              div_ge;
    logic [2*XLEN-1:0] step, mul_full;
    logic [XLEN-1:0]   m_res;

    always_comb begin
        add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
        div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_rem   = div_shift[XLEN-1:0] - b_q;
        if (f3_q[2]) begin
            step = {div_ge ? div_rem : div_shift[XLEN-1:0], prod_q[XLEN-2:0], div_ge};
        end else begin
            step = {add_sum, prod_q[XLEN-1:1]};
        end
        mul_full = neg_q ? -step : step;
        quo      = step[XLEN-1:0];
        rem      = step[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:          m_res = mul_full[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          m_res = mul_full[2*XLEN-1:XLEN];
            3'b100, 3'b101:  m_res = dz_q ? '1 : (neg_q ? -quo : quo);
            default:         m_res = dz_q ? a_raw_q : (a_neg_q ? -rem : rem);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        b_d      = b_q;
        a_raw_d  = a_raw_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        dz_d     = dz_q;
        result_d = result_q;
        branch_d = branch_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_m) begin
                        state_d = StIter;
                        cnt_d   = SHW'(XLEN - 1);
                        prod_d  = {{XLEN{1'b0}}, a_mag};
                        b_d     = b_mag;
                        a_raw_d = reg1;
                        f3_d    = funct3;
                        neg_d   = a_neg ^ b_neg;
                        a_neg_d = a_neg;
                        dz_d    = reg2 == '0;
                    end else begin
                        state_d  = StDone;
                        result_d = base_res;
                        branch_d = base_br;
                    end
                end
            end
            StIter: begin
                prod_d = step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = StDone;
                    cnt_d    = '0;
                    result_d = m_res;
                    branch_d = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prod_q   <= '0;
            b_q      <= '0;
            a_raw_q  <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            b_q      <= b_d;
            a_raw_q  <= a_raw_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    assign in_ready  = state_q == StIdle;
    assign out_valid = state_q == StDone;
    assign busy      = state_q == StIter;
    assign result    = result_q;
    assign branch    = branch_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: base, branch, M ops, backpressure, reset abort, XLEN=16.
module tb_seq_alu;

    localparam logic [6:0] OpR = 7'b0110011;
    localparam logic [6:0] OpI = 7'b0010011;
    localparam logic [6:0] OpB = 7'b1100011;
    localparam logic [6:0] F0  = 7'b0000000;
    localparam logic [6:0] FA  = 7'b0100000;
    localparam logic [6:0] FM  = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, branch, busy, src;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] reg1, reg2, immediate, result;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, branch16, busy16;
    logic [15:0] reg1_16, reg2_16, result16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .ALU_source(src),
        .reg1(reg1), .reg2(reg2), .immediate(immediate),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .branch(branch), .busy(busy)
    );

    seq_alu #(.XLEN(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .ALU_source(1'b0),
        .reg1(reg1_16), .reg2(reg2_16), .immediate(16'h0000),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .branch(branch16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic s, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] imm,
                          input logic [31:0] exp_res, input logic exp_br, input int exp_lat);
        int lat;
        int busy_cnt;
        @(negedge clk);
        opcode = op; funct3 = f3; funct7 = f7; src = s;
        reg1 = r1; reg2 = r2; immediate = imm;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        check({tag, "_br"}, 64'(branch), 64'(exp_br));
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run16(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [15:0] r1, input logic [15:0] r2,
                         input logic [15:0] exp_res, input int exp_lat);
        int lat;
        @(negedge clk);
        opcode = OpR; funct3 = f3; funct7 = f7;
        reg1_16 = r1; reg2_16 = r2; in_valid16 = 1'b1; out_ready16 = 1'b0;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, 64'(result16), 64'(exp_res));
        check({tag, "_br"}, 64'(branch16), 64'd0);
        @(negedge clk) out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
    endtask

    initial begin
        int ov_cnt;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; src = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0; reg1 = '0; reg2 = '0; immediate = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; reg1_16 = '0; reg2_16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_branch", 64'(branch), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Base ALU ops
        run_op("add",   OpR, 3'b000, F0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1);
        run_op("sub",   OpR, 3'b000, FA, 1'b0, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("sra",   OpR, 3'b101, FA, 1'b0, 32'h8000_0000, 32'h24, 32'd0,
               32'hF800_0000, 1'b0, 1);
        run_op("srl",   OpR, 3'b101, F0, 1'b0, 32'h8000_0000, 32'h24, 32'd0,
               32'h0800_0000, 1'b0, 1);
        run_op("slli",  OpI, 3'b001, F0, 1'b1, 32'd1, 32'd5, 32'd32, 32'd1, 1'b0, 1);
        run_op("slt",   OpR, 3'b010, F0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b0, 1);
        run_op("sltu",  OpR, 3'b011, F0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1);
        run_op("xor",   OpR, 3'b100, F0, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,
               32'hFF00_0FF0, 1'b0, 1);
        run_op("or",    OpR, 3'b110, F0, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,
               32'hFFF0_0FFF, 1'b0, 1);
        run_op("and",   OpR, 3'b111, F0, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,
               32'h00F0_000F, 1'b0, 1);
        run_op("addi",  OpI, 3'b000, F0, 1'b1, 32'd10, 32'd99, 32'hFFFF_FFFF, 32'd9, 1'b0, 1);

        // Branches
        run_op("blt",   OpB, 3'b100, F0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1);
        run_op("bltu",  OpB, 3'b110, F0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1);
        run_op("beq",   OpB, 3'b000, F0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 1'b1, 1);
        run_op("bne",   OpB, 3'b001, F0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 1);
        run_op("bge",   OpB, 3'b101, F0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1);
        run_op("bgeu",  OpB, 3'b111, F0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1);

        // Unsupported encodings
        run_op("bad_op",  7'h7F, 3'b000, F0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1);
        run_op("bad_f7",  OpR, 3'b100, FA, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1);

        // M extension
        run_op("mul",    OpR, 3'b000, FM, 1'b0, 32'd6, 32'hFFFF_FFFD, 32'd0,
               32'hFFFF_FFEE, 1'b0, 33);
        run_op("mulh",   OpR, 3'b001, FM, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
               32'd0, 1'b0, 33);
        run_op("mulhu",  OpR, 3'b011, FM, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
               32'hFFFF_FFFE, 1'b0, 33);
        run_op("mulhsu", OpR, 3'b010, FM, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
               32'hFFFF_FFFF, 1'b0, 33);
        run_op("div_ovf", OpR, 3'b100, FM, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
               32'h8000_0000, 1'b0, 33);
        run_op("rem_ovf", OpR, 3'b110, FM, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
               32'd0, 1'b0, 33);
        run_op("divu_z", OpR, 3'b101, FM, 1'b0, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("div_nz", OpR, 3'b100, FM, 1'b0, 32'hFFFF_FFF9, 32'd0, 32'd0,
               32'hFFFF_FFFF, 1'b0, 33);
        run_op("rem_z",  OpR, 3'b110, FM, 1'b0, 32'd7, 32'd0, 32'd0, 32'd7, 1'b0, 33);
        run_op("rem_nz", OpR, 3'b110, FM, 1'b0, 32'hFFFF_FFF9, 32'd0, 32'd0,
               32'hFFFF_FFF9, 1'b0, 33);
        run_op("rem_neg", OpR, 3'b110, FM, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0,
               32'hFFFF_FFFF, 1'b0, 33);
        run_op("div_neg", OpR, 3'b100, FM, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0,
               32'hFFFF_FFFD, 1'b0, 33);
        run_op("divu",   OpR, 3'b101, FM, 1'b0, 32'd100, 32'd7, 32'd0, 32'd14, 1'b0, 33);
        run_op("remu",   OpR, 3'b111, FM, 1'b0, 32'd100, 32'd7, 32'd0, 32'd2, 1'b0, 33);

        // Backpressure in DONE; new requests must be ignored
        @(negedge clk);
        opcode = OpR; funct3 = 3'b000; funct7 = F0; src = 1'b0;
        reg1 = 32'd20; reg2 = 32'd22; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        reg1 = 32'd1000;
        check("stall_ov0", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_res", 64'(result), 64'd42);
            check("stall_rdy", 64'(in_ready), 64'd0);
            check("stall_ov", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("drain_ov", 64'(out_valid), 64'd0);
        check("drain_rdy", 64'(in_ready), 64'd1);

        // Reset mid-ITER, asserted alongside in_valid/out_ready
        @(negedge clk);
        funct7 = FM; funct3 = 3'b000; reg1 = 32'd3; reg2 = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("abort_rdy", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_res", 64'(result), 64'd0);
        ov_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov_cnt++;
        end
        check("abort_no_ov", 64'(ov_cnt), 64'd0);

        // XLEN = 16 instance
        run16("add16",  3'b000, F0, 16'd5, 16'd7, 16'd12, 1);
        run16("divu16", 3'b101, FM, 16'd100, 16'd7, 16'd14, 17);
        run16("mulhu16", 3'b011, FM, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
